// File: rtl/bus_pkg.sv
// Shared defaults, arbiter state encoding and index helpers for bus_matrix and rr_arbiter.
// Instances override the width defaults through their own parameters.
package bus_pkg;

  localparam int unsigned BUS_NUM_M    = 2;
  localparam int unsigned BUS_NUM_S    = 2;
  localparam int unsigned BUS_ADDR_W   = 8;
  localparam int unsigned BUS_DATA_W   = 32;
  localparam int unsigned BUS_REGION_W = 5;
  localparam int unsigned BUS_TIMEOUT  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } bus_state_e;

  // Index width that never collapses to zero bits for a single-entry vector.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold; grant registered 1 cycle after request, no backpressure.
// The owner keeps the bus while hold_i is high unless force_i hands it to the next requester.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_M = BUS_NUM_M
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NUM_M-1:0] req_i,
  input  logic             hold_i,
  input  logic             force_i,
  output logic [NUM_M-1:0] grant_o
);

  localparam int unsigned IW = clog2_safe(NUM_M);

  bus_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [NUM_M-1:0] cand, masked, win_oh;
  logic [IW-1:0]    win, win_u, win_m, ptr_nxt;
  logic             found;

  // Masked-priority search: lowest candidate at or after rr_ptr, else lowest overall (wrap).
  always_comb begin
    cand   = force_i ? (req_i & ~grant_q) : req_i;
    masked = '0;
    win_u  = '0;
    win_m  = '0;
    win_oh = '0;
    for (int i = 0; i < NUM_M; i++) masked[i] = cand[i] && (i >= int'(ptr_q));
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (cand[i])   win_u = IW'(i);
      if (masked[i]) win_m = IW'(i);
    end
    found = |cand;
    win   = (masked != '0) ? win_m : win_u;
    for (int i = 0; i < NUM_M; i++) win_oh[i] = (win == IW'(i));
    ptr_nxt = (int'(win) == NUM_M - 1) ? '0 : win + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_OWNED;
          grant_d = win_oh;
          ptr_d   = ptr_nxt;
        end
      end
      ST_OWNED: begin
        if (!hold_i || force_i) begin
          if (found) begin
            grant_d = win_oh;
            ptr_d   = ptr_nxt;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: rtl/bus_matrix.sv
// Shared bus for NUM_M masters / NUM_S slaves: grant 1 cycle after request, read data 1 cycle after select, no backpressure.
// BUS_TIMEOUT_EN adds a hold counter that forces hand-over after TIMEOUT cycles when others are waiting.
module bus_matrix
  import bus_pkg::*;
#(
  parameter int unsigned NUM_M    = BUS_NUM_M,
  parameter int unsigned NUM_S    = BUS_NUM_S,
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned DATA_W   = BUS_DATA_W,
  parameter int unsigned REGION_W = BUS_REGION_W,
  parameter int unsigned TIMEOUT  = BUS_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M-1:0]        m_wr,
  input  logic [NUM_M*ADDR_W-1:0] m_addr,
  input  logic [NUM_M*DATA_W-1:0] m_dout,
  output logic [NUM_M-1:0]        m_grant,
  output logic [DATA_W-1:0]       m_din,
  output logic [NUM_S-1:0]        s_sel,
  output logic                    s_wr,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_din,
  input  logic [NUM_S*DATA_W-1:0] s_dout
);

  localparam int unsigned SW = clog2_safe(NUM_S);

  if (NUM_M < 1 || NUM_M > 8 || NUM_S < 1 || NUM_S > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bus_matrix: NUM_M/NUM_S must be 1..8 and TIMEOUT >= 1");
  end

  logic              owned, hold, force_ho, hit, own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_dout;
  logic [NUM_S-1:0]  sel;
  logic              rd_vld_q, rd_vld_d;
  logic [SW-1:0]     rd_idx_q, rd_idx_d;

  rr_arbiter #(.NUM_M(NUM_M)) u_arb (
    .clk_i   (clk),
    .rst_i   (reset),
    .req_i   (m_req),
    .hold_i  (hold),
    .force_i (force_ho),
    .grant_o (m_grant)
  );

  always_comb begin
    own_wr   = 1'b0;
    own_addr = '0;
    own_dout = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (m_grant[i]) begin
        own_wr   = m_wr[i];
        own_addr = m_addr[i*ADDR_W +: ADDR_W];
        own_dout = m_dout[i*DATA_W +: DATA_W];
      end
    end
    owned = |m_grant;
    hold  = |(m_grant & m_req);
    for (int j = 0; j < NUM_S; j++) sel[j] = owned && ((own_addr >> REGION_W) == ADDR_W'(j));
    hit = |sel;
  end

  // Out-of-range or idle bus drives all-zero so no slave can latch a stray write.
  assign s_sel  = sel;
  assign s_wr   = hit & own_wr;
  assign s_addr = hit ? own_addr : '0;
  assign s_din  = hit ? own_dout : '0;

  assign rd_vld_d = hit;
  assign rd_idx_d = SW'(onehot_to_idx(8'(sel)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  always_comb begin
    m_din = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (rd_vld_q && rd_idx_q == SW'(j)) m_din = s_dout[j*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = clog2_safe(TIMEOUT);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          others;

  // hold_cnt_q counts owned cycles already completed, so the forcing edge ends cycle TIMEOUT.
  assign others     = |(m_req & ~m_grant);
  assign force_ho   = hold && others && (hold_cnt_q == CW'(TIMEOUT - 1));
  assign hold_cnt_d = (hold && !force_ho)
                    ? ((hold_cnt_q == CW'(TIMEOUT - 1)) ? hold_cnt_q : hold_cnt_q + 1'b1)
                    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  assign force_ho = 1'b0;
`endif

endmodule

// File: tb/tb_bus_matrix.sv
// Self-checking bench for bus_matrix (4 masters, 2 slaves): directed scenarios plus a randomized run
// against a transaction-level reference model; timeout expectations follow BUS_TIMEOUT_EN.
module tb_bus_matrix;

  localparam int NM = 4, NS = 2, AW = 8, DW = 32, RW = 5, TO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_req, m_wr, m_grant;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_dout;
  logic [DW-1:0]    m_din, s_din;
  logic [NS-1:0]    s_sel;
  logic             s_wr;
  logic [AW-1:0]    s_addr;
  logic [NS*DW-1:0] s_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_matrix #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .REGION_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout)
  );

  // Synchronous-read slaves (read-before-write), cleared by reset.
  logic [DW-1:0] mem   [NS][32];
  logic [DW-1:0] rdata [NS];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NS; j++) begin
        rdata[j] <= '0;
        for (int k = 0; k < 32; k++) mem[j][k] <= '0;
      end
    end else begin
      for (int j = 0; j < NS; j++) begin
        if (s_sel[j]) begin
          rdata[j] <= mem[j][s_addr[4:0]];
          if (s_wr) mem[j][s_addr[4:0]] <= s_din;
        end
      end
    end
  end
  assign s_dout = {rdata[1], rdata[0]};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0;
  endtask

  task automatic set_m(input int i, input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[i] = req; m_wr[i] = wr; m_addr[i*AW +: AW] = a; m_dout[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1 reset = 1'b1;
    set_m(0, 1'b1, 1'b1, 8'h03, 32'h1234_5678);
    #2;
    n_vec++; if (m_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", m_grant); end
    n_vec++; if (s_sel !== 2'b00) begin n_err++; $display("FAIL reset_sel got %b want 00", s_sel); end
    n_vec++; if (s_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b want 0", s_wr); end
    n_vec++; if (s_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", s_addr); end
    n_vec++; if (s_din !== 32'h0) begin n_err++; $display("FAIL reset_din got %h want 0", s_din); end
    n_vec++; if (m_din !== 32'h0) begin n_err++; $display("FAIL reset_mdin got %h want 0", m_din); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    cyc();
    n_vec++; if (m_grant !== 4'b0000) begin n_err++; $display("FAIL reset_idle_grant got %b want 0000", m_grant); end
  endtask

  task automatic test_write_read();
    apply_reset();
    set_m(0, 1'b1, 1'b1, 8'h03, 32'hDEAD_BEEF);
    cyc();
    n_vec++; if (m_grant !== 4'b0001) begin n_err++; $display("FAIL wr_grant got %b want 0001", m_grant); end
    n_vec++; if (s_sel !== 2'b01) begin n_err++; $display("FAIL wr_sel got %b want 01", s_sel); end
    n_vec++; if (s_wr !== 1'b1) begin n_err++; $display("FAIL wr_strobe got %b want 1", s_wr); end
    n_vec++; if (s_addr !== 8'h03) begin n_err++; $display("FAIL wr_addr got %h want 03", s_addr); end
    n_vec++; if (s_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_din got %h want deadbeef", s_din); end
    cyc();
    set_m(0, 1'b1, 1'b0, 8'h03, 32'h0);
    #1;
    n_vec++; if (s_sel !== 2'b01 || s_wr !== 1'b0) begin n_err++; $display("FAIL rd_present got sel=%b wr=%b want sel=01 wr=0", s_sel, s_wr); end
    cyc();
    n_vec++; if (m_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", m_din); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_arbitration();
    apply_reset();
    set_m(0, 1'b1, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'h00, 32'h0);
    cyc();
    n_vec++; if (m_grant !== 4'b0001) begin n_err++; $display("FAIL arb_first got %b want 0001", m_grant); end
    m_req[0] = 1'b0;
    cyc();
    n_vec++; if (m_grant !== 4'b0010) begin n_err++; $display("FAIL arb_handover got %b want 0010", m_grant); end
    idle_inputs();
    cyc();
    n_vec++; if (m_grant !== 4'b0000) begin n_err++; $display("FAIL arb_release got %b want 0000", m_grant); end
    m_req = 4'b0011;
    cyc();
    n_vec++; if (m_grant !== 4'b0001) begin n_err++; $display("FAIL arb_fair got %b want 0001", m_grant); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_rr_ptr();
    apply_reset();
    set_m(1, 1'b1, 1'b0, 8'h00, 32'h0);
    cyc();
    n_vec++; if (m_grant !== 4'b0010) begin n_err++; $display("FAIL rr_m1 got %b want 0010", m_grant); end
    idle_inputs();
    cyc();
    m_req = 4'b1010;
    cyc();
    n_vec++; if (m_grant !== 4'b1000) begin n_err++; $display("FAIL rr_m3_first got %b want 1000", m_grant); end
    m_req[3] = 1'b0;
    cyc();
    n_vec++; if (m_grant !== 4'b0010) begin n_err++; $display("FAIL rr_m1_next got %b want 0010", m_grant); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_decode();
    apply_reset();
    set_m(0, 1'b1, 1'b1, 8'h25, 32'hCAFE_0001);
    cyc();
    n_vec++; if (s_sel !== 2'b10 || s_wr !== 1'b1) begin n_err++; $display("FAIL dec_alu got sel=%b wr=%b want sel=10 wr=1", s_sel, s_wr); end
    cyc();
    set_m(0, 1'b1, 1'b1, 8'h45, 32'hBAD0_BAD0);
    #1;
    n_vec++; if (s_sel !== 2'b00 || s_wr !== 1'b0) begin n_err++; $display("FAIL dec_oor got sel=%b wr=%b want sel=00 wr=0", s_sel, s_wr); end
    n_vec++; if (s_addr !== 8'h00 || s_din !== 32'h0) begin n_err++; $display("FAIL dec_oor_bus got addr=%h din=%h want 0", s_addr, s_din); end
    cyc();
    set_m(0, 1'b1, 1'b0, 8'h45, 32'h0);
    cyc();
    n_vec++; if (m_din !== 32'h0) begin n_err++; $display("FAIL dec_oor_read got %h want 0", m_din); end
    set_m(0, 1'b1, 1'b0, 8'h25, 32'h0);
    cyc();
    n_vec++; if (m_din !== 32'hCAFE_0001) begin n_err++; $display("FAIL dec_alu_read got %h want cafe0001", m_din); end
    set_m(0, 1'b1, 1'b0, 8'h05, 32'h0);
    cyc();
    n_vec++; if (m_din !== 32'h0) begin n_err++; $display("FAIL dec_no_alias got %h want 0", m_din); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_midtransfer();
    apply_reset();
    set_m(1, 1'b1, 1'b1, 8'h23, 32'h5A5A_1234);
    cyc();
    cyc();
    set_m(1, 1'b1, 1'b0, 8'h23, 32'h0);
    cyc();
    n_vec++; if (m_din !== 32'h5A5A_1234) begin n_err++; $display("FAIL mid_pre_read got %h want 5a5a1234", m_din); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (m_grant !== 4'b0000 || s_sel !== 2'b00 || m_din !== 32'h0) begin
      n_err++; $display("FAIL mid_reset got grant=%b sel=%b din=%h want all 0", m_grant, s_sel, m_din);
    end
    set_m(2, 1'b1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    n_vec++; if (m_grant !== 4'b0010) begin n_err++; $display("FAIL mid_post_grant got %b want 0010", m_grant); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_timeout();
    logic [NM-1:0] exp_g;
    apply_reset();
    set_m(0, 1'b1, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'h00, 32'h0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      exp_g = (TMO && c >= TO) ? 4'b0010 : 4'b0001;
      n_vec++; if (m_grant !== exp_g) begin n_err++; $display("FAIL timeout_c%0d got %b want %b", c, m_grant, exp_g); end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_random();
    int owner, ptr, held, w, k, slv, off;
    bit others;
    logic [DW-1:0] exp_din, e_din;
    logic [DW-1:0] refm [NS][32];
    logic [NM-1:0] e_gnt;
    logic [NS-1:0] e_sel;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    owner = -1; ptr = 0; held = 0; slv = 0; exp_din = '0;
    for (int j = 0; j < NS; j++) for (int a = 0; a < 32; a++) refm[j][a] = '0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(3) == 0) m_req[i] = ~m_req[i];
        m_wr[i] = 1'($urandom_range(1));
        m_addr[i*AW +: AW] = AW'($urandom_range(95));
        m_dout[i*DW +: DW] = $urandom();
      end
      #1;
      e_gnt = '0; e_sel = '0; e_wr = 1'b0; e_addr = '0; e_din = '0;
      if (owner >= 0) begin
        e_gnt[owner] = 1'b1;
        slv = int'(m_addr[owner*AW +: AW]) / 32;
        if (slv < NS) begin
          e_sel[slv] = 1'b1;
          e_wr   = m_wr[owner];
          e_addr = m_addr[owner*AW +: AW];
          e_din  = m_dout[owner*DW +: DW];
        end
      end
      n_vec++; if (m_grant !== e_gnt) begin n_err++; $display("FAIL rnd_grant c%0d got %b want %b", c, m_grant, e_gnt); end
      n_vec++; if (s_sel !== e_sel || s_wr !== e_wr) begin n_err++; $display("FAIL rnd_sel c%0d got %b/%b want %b/%b", c, s_sel, s_wr, e_sel, e_wr); end
      n_vec++; if (s_addr !== e_addr || s_din !== e_din) begin n_err++; $display("FAIL rnd_bus c%0d got %h/%h want %h/%h", c, s_addr, s_din, e_addr, e_din); end
      n_vec++; if (m_din !== exp_din) begin n_err++; $display("FAIL rnd_mdin c%0d got %h want %h", c, m_din, exp_din); end
      @(posedge clk);
      if (e_sel != '0) begin
        off = int'(e_addr) % 32;
        exp_din = refm[slv][off];
        if (e_wr) refm[slv][off] = e_din;
      end else begin
        exp_din = '0;
      end
      others = 1'b0;
      for (int i = 0; i < NM; i++) if (i != owner && m_req[i]) others = 1'b1;
      if (owner >= 0 && m_req[owner] && !(TMO && held >= TO && others)) begin
        held++;
      end else begin
        w = -1;
        for (int o = 0; o < NM; o++) begin
          k = (ptr + o) % NM;
          if (w < 0 && k != owner && m_req[k]) w = k;
        end
        if (w >= 0) begin owner = w; ptr = (w + 1) % NM; held = 1; end
        else begin owner = -1; held = 0; end
      end
      #1;
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_rr_ptr();
    test_decode();
    test_reset_midtransfer();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_matrix.md
# bus_matrix

Parametrised shared-bus interconnect that connects NUM_M masters to NUM_S memory-mapped slaves (RAM, ALU/multiplier, future peripherals) through one registered, round-robin-arbitrated bus. It replaces the single-master two-slave bus in the top level. It performs:
- arbitration and grant hold;
- address decode into per-slave selects;
- write/address/data broadcast;
- read-data return routing.

## Interface
Parameters:
- NUM_M, 2: number of masters (1..8)
- NUM_S, 2: number of slaves (1..8)
- ADDR_W, 8: address width
- DATA_W, 32: data width
- REGION_W, 5: log2 of bytes/words per slave region; slave index = addr >> REGION_W
- TIMEOUT, 16: maximum consecutive grant cycles (used only with BUS_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- m_req  in  NUM_M  per-master bus request
- m_wr  in  NUM_M  per-master write strobe (1 = write, 0 = read)
- m_addr  in  NUM_M*ADDR_W  packed master addresses, master i at [i*ADDR_W +: ADDR_W]
- m_dout  in  NUM_M*DATA_W  packed master write data
- m_grant  out  NUM_M  one-hot or zero grant, registered
- m_din  out  DATA_W  read data returned to the granted master
- s_sel  out  NUM_S  one-hot or zero slave select
- s_wr  out  1  write strobe to slaves
- s_addr  out  ADDR_W  address to slaves
- s_din  out  DATA_W  write data to slaves
- s_dout  in  NUM_S*DATA_W  packed slave read data, slave j at [j*DATA_W +: DATA_W]

## Operation
States:
- IDLE: m_grant == 0.
- OWNED(k): m_grant[k] == 1.

Transitions, evaluated at each rising edge:
- From IDLE, any m_req set → OWNED(winner). Winner is the first requester at or after rr_ptr in ascending index order, wrapping from NUM_M-1 to 0.
- From OWNED(k), m_req[k] still high → stay OWNED(k).
- From OWNED(k), m_req[k] low and other requests pending → OWNED(winner) directly, with no idle cycle.
- From OWNED(k), m_req[k] low and no requests pending → IDLE.
- rr_ptr becomes (winner+1) mod NUM_M on every new grant.

Bus outputs (combinational from m_grant and the owner's inputs):
- s_addr, s_wr and s_din mirror the owner's m_addr, m_wr and m_dout.
- s_sel[j] = 1 only when owned and (s_addr >> REGION_W) == j.
- With no owner, or an out-of-range index (>= NUM_S), s_sel = 0, s_wr = 0, s_addr = 0 and s_din = 0.
- No slave is written when the address is out of range.

Read return:
- rd_idx and rd_vld are registered from the current decode every cycle.
- m_din = s_dout[rd_idx] when rd_vld, else 0. Slaves are synchronous-read, so data returns one cycle after select.
- m_din is broadcast to all masters. Only the master granted in the previous cycle may consume it.

## Timing
- Reset values: m_grant=0, rr_ptr=0, rd_vld=0, rd_idx=0. Hence m_din=0, s_sel=0, s_wr=0, s_addr=0 and s_din=0.
- Request-to-grant latency is 1 cycle: m_req rising before edge n gives m_grant high after edge n.
- Read latency is 1 cycle after the address is presented with grant high.
- Write takes effect at the same edge the slave samples s_sel/s_wr.
- Simultaneous release by the owner and a new request from another master: the other master is granted at the same edge.
- Reset asserted mid-transfer: everything returns to reset values immediately (asynchronous). Any in-flight write is not guaranteed.
- NUM_M=1: the arbiter degenerates to grant = req, registered.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A hold counter counts consecutive OWNED(k) cycles for the same owner.
  - When the counter reaches TIMEOUT with another request pending, ownership is forcibly passed to the next round-robin requester at that edge.
  - The counter clears on any grant change and on reset.
  - If no other master requests, the owner keeps the bus indefinitely.
- BUS_TIMEOUT_EN undefined: no counter; ownership ends only when the owner drops m_req. TIMEOUT is ignored.

## Structure
- Shared package bus_pkg holds:
  - default width constants;
  - the state encoding (IDLE/OWNED);
  - a function clog2_safe(n) returning at least 1, used for index widths;
  - a function onehot_to_idx.
- Sub-module rr_arbiter(NUM_M) contains the masked-priority search and rr_ptr. It takes req, hold and force (force is tied 0 without BUS_TIMEOUT_EN) and returns the registered grant.
- bus_matrix keeps the decode, the muxing and the read-return register.

## Test plan
- Reset, then master 0 writes 0xDEADBEEF to addr 0x03 → s_sel=2'b01 and s_wr=1. A following read of 0x03 returns m_din=0xDEADBEEF one cycle after select.
- Masters 0 and 1 request together from reset → grant 2'b01. After m_req[0] drops, grant is 2'b10 at the next edge with no idle cycle. The next simultaneous request goes to master 0 (fairness).
- Address 0x25 → s_sel=2'b10 (ALU slave). Address 0x45 with NUM_S=2 → s_sel=0, write suppressed, read m_din=0.
- NUM_M=4: masters 1 and 3 request with rr_ptr=2 → master 3 is granted first, then master 1.
- Reset asserted while master 1 is owning and reading → m_grant, s_sel and m_din are 0 immediately, and the first post-reset grant follows rr_ptr=0.
- With BUS_TIMEOUT_EN and TIMEOUT=4: master 0 holds its request while master 1 requests → master 0 is granted for exactly 4 cycles, then grant moves to 2'b10.
